// File: rtl/ddr2_pkg.sv
// Shared constants, state enum and small helpers for the DDR2 init sequencer.
package ddr2_pkg;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_LMR  = 4'b0000;

    // Bank-address codes selecting the mode register
    localparam int BA_MR   = 0;
    localparam int BA_EMR1 = 1;
    localparam int BA_EMR2 = 2;
    localparam int BA_EMR3 = 3;

    // Address-bit positions with fixed meaning during init
    localparam int A10_AP     = 10;  // precharge-all
    localparam int A8_DLLRST  = 8;   // DLL reset in MR
    localparam int A9_7_OCD   = 7;   // low bit of the 3-bit OCD field in EMR1
    localparam int A0_DLLDIS  = 0;   // DLL disable in EMR1

    typedef enum logic [3:0] {
        S_PWR,
        S_CKE,
        S_PRE1,
        S_EMR2,
        S_EMR3,
        S_EMR1,
        S_MR_DLLRST,
        S_PRE2,
        S_AREF,
        S_MR,
        S_OCD_DEF,
        S_OCD_EXIT,
        S_DLLW,
        S_DONE
    } state_t;

    // Down-counter load value that makes the next event land T cycles later
    function automatic int gap_load(input int t);
        return (t > 1) ? t - 1 : 0;
    endfunction

endpackage

// File: rtl/ddr2_init_seq_if.sv
// Command bus from the init sequencer toward the PHY command mux / controller.
interface ddr2_init_seq_if #(
    parameter int ADDR_BITS = 14,
    parameter int BA_BITS   = 3
);
    logic                 init_cke;
    logic [3:0]           init_cmd;
    logic [BA_BITS-1:0]   init_ba;
    logic [ADDR_BITS-1:0] init_addr;
    logic                 init_busy;
    logic                 init_done;

    modport master (
        output init_cke, init_cmd, init_ba, init_addr, init_busy, init_done
    );

    modport slave (
        input init_cke, init_cmd, init_ba, init_addr, init_busy, init_done
    );
endinterface

// File: rtl/ddr2_init_timer.sv
// Loadable down counter that stops at zero; used for command gaps and DLL lock.
module ddr2_init_timer #(
    parameter int               CNT_W   = 17,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             ck,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] value,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    // Load has priority; otherwise count down and hold at zero
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n)
            cnt <= RST_VAL;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign value = cnt;
    assign zero  = (cnt == '0);

endmodule

// File: rtl/ddr2_init_seq.sv
// DDR2 power-up / re-initialisation sequencer driving CKE, command, bank and address.
module ddr2_init_seq
    import ddr2_pkg::*;
#(
    parameter int ADDR_BITS = 14,
    parameter int BA_BITS   = 3,
    parameter int T_POWERUP = 60000,
    parameter int T_NOP     = 80,
    parameter int T_RP      = 3,
    parameter int T_MRD     = 2,
    parameter int T_RFC     = 26,
    parameter int N_AREF    = 2,
    parameter int T_DLLK    = 200,
    parameter int CNT_W     = 17
) (
    input  logic                 ck,
    input  logic                 rst_n,
    input  logic [ADDR_BITS-1:0] mr_val,
    input  logic [ADDR_BITS-1:0] emr1_val,
    input  logic [ADDR_BITS-1:0] emr2_val,
    input  logic [ADDR_BITS-1:0] emr3_val,
    input  logic                 reinit_req,
    ddr2_init_seq_if.master      bus
);

    localparam logic [ADDR_BITS-1:0] AP_BIT     = ADDR_BITS'(1 << A10_AP);
    localparam logic [ADDR_BITS-1:0] DLLRST_BIT = ADDR_BITS'(1 << A8_DLLRST);
    localparam logic [ADDR_BITS-1:0] OCD_MASK   = ADDR_BITS'(7 << A9_7_OCD);
    localparam logic [ADDR_BITS-1:0] DLLDIS_BIT = ADDR_BITS'(1 << A0_DLLDIS);

    localparam logic [CNT_W-1:0] LD_PWR  = CNT_W'(gap_load(T_POWERUP));
    localparam logic [CNT_W-1:0] LD_NOP  = CNT_W'(gap_load(T_NOP));
    localparam logic [CNT_W-1:0] LD_RP   = CNT_W'(gap_load(T_RP));
    localparam logic [CNT_W-1:0] LD_MRD  = CNT_W'(gap_load(T_MRD));
    localparam logic [CNT_W-1:0] LD_RFC  = CNT_W'(gap_load(T_RFC));
    localparam logic [CNT_W-1:0] LD_DLLK = CNT_W'(T_DLLK);
    localparam logic [3:0]       AREF_N  = 4'(N_AREF);

    state_t               state, state_nxt;
    logic                 cke_q, cke_nxt;
    logic [3:0]           cmd_q, cmd_nxt;
    logic [BA_BITS-1:0]   ba_q, ba_nxt;
    logic [ADDR_BITS-1:0] addr_q, addr_nxt;
    logic                 busy_q, busy_nxt;
    logic                 done_q, done_nxt;

    logic                 gap_ld, gap_zero;
    logic [CNT_W-1:0]     gap_ld_val, gap_val;
    logic                 dll_ld, dll_zero;
    logic [CNT_W-1:0]     dll_val;
    logic                 unused_tmr_val;

    logic [3:0]           aref_cnt;
    logic                 aref_clr, aref_inc;
    logic                 capture;

    logic [ADDR_BITS-1:0] mr_sh, emr1_sh, emr2_sh, emr3_sh;
    logic [ADDR_BITS-1:0] emr1_base;

    // EMR1 with DLL enabled and OCD field cleared; OCD commands OR the field back in
    assign emr1_base = emr1_sh & ~(OCD_MASK | DLLDIS_BIT);

    // Gap timer starts pre-loaded so the power-up wait needs no extra state
    ddr2_init_timer #(.CNT_W(CNT_W), .RST_VAL(LD_PWR)) u_gap_tmr (
        .ck       (ck),
        .rst_n    (rst_n),
        .load     (gap_ld),
        .load_val (gap_ld_val),
        .value    (gap_val),
        .zero     (gap_zero)
    );

    ddr2_init_timer #(.CNT_W(CNT_W), .RST_VAL('0)) u_dll_tmr (
        .ck       (ck),
        .rst_n    (rst_n),
        .load     (dll_ld),
        .load_val (LD_DLLK),
        .value    (dll_val),
        .zero     (dll_zero)
    );

    assign unused_tmr_val = ^{gap_val, dll_val};

    // State register
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n)
            state <= S_PWR;
        else
            state <= state_nxt;
    end

    // Next state and next registered outputs; a command is issued on entry to its state
    always_comb begin
        state_nxt  = state;
        cke_nxt    = 1'b1;
        cmd_nxt    = CMD_NOP;
        ba_nxt     = '0;
        addr_nxt   = '0;
        busy_nxt   = busy_q;
        done_nxt   = done_q;
        gap_ld     = 1'b0;
        gap_ld_val = LD_MRD;
        dll_ld     = 1'b0;
        aref_clr   = 1'b0;
        aref_inc   = 1'b0;
        capture    = 1'b0;
        unique case (state)
            S_PWR: begin
                cke_nxt = 1'b0;
                if (gap_zero) begin
                    state_nxt  = S_CKE;
                    cke_nxt    = 1'b1;
                    gap_ld     = 1'b1;
                    gap_ld_val = LD_NOP;
                end
            end
            S_CKE: if (gap_zero) begin
                state_nxt  = S_PRE1;
                cmd_nxt    = CMD_PRE;
                addr_nxt   = AP_BIT;
                gap_ld     = 1'b1;
                gap_ld_val = LD_RP;
                capture    = 1'b1;
            end
            S_PRE1: if (gap_zero) begin
                state_nxt = S_EMR2;
                cmd_nxt   = CMD_LMR;
                ba_nxt    = BA_BITS'(BA_EMR2);
                addr_nxt  = emr2_sh;
                gap_ld    = 1'b1;
            end
            S_EMR2: if (gap_zero) begin
                state_nxt = S_EMR3;
                cmd_nxt   = CMD_LMR;
                ba_nxt    = BA_BITS'(BA_EMR3);
                addr_nxt  = emr3_sh;
                gap_ld    = 1'b1;
            end
            S_EMR3: if (gap_zero) begin
                state_nxt = S_EMR1;
                cmd_nxt   = CMD_LMR;
                ba_nxt    = BA_BITS'(BA_EMR1);
                addr_nxt  = emr1_base;
                gap_ld    = 1'b1;
            end
            S_EMR1: if (gap_zero) begin
                state_nxt = S_MR_DLLRST;
                cmd_nxt   = CMD_LMR;
                ba_nxt    = BA_BITS'(BA_MR);
                addr_nxt  = mr_sh | DLLRST_BIT;
                gap_ld    = 1'b1;
                dll_ld    = 1'b1;
            end
            S_MR_DLLRST: if (gap_zero) begin
                state_nxt  = S_PRE2;
                cmd_nxt    = CMD_PRE;
                addr_nxt   = AP_BIT;
                gap_ld     = 1'b1;
                gap_ld_val = LD_RP;
                aref_clr   = 1'b1;
            end
            S_PRE2: if (gap_zero) begin
                state_nxt  = S_AREF;
                cmd_nxt    = CMD_AREF;
                gap_ld     = 1'b1;
                gap_ld_val = LD_RFC;
                aref_inc   = 1'b1;
            end
            S_AREF: if (gap_zero) begin
                gap_ld = 1'b1;
                if (aref_cnt >= AREF_N) begin
                    state_nxt = S_MR;
                    cmd_nxt   = CMD_LMR;
                    ba_nxt    = BA_BITS'(BA_MR);
                    addr_nxt  = mr_sh & ~DLLRST_BIT;
                end else begin
                    cmd_nxt    = CMD_AREF;
                    gap_ld_val = LD_RFC;
                    aref_inc   = 1'b1;
                end
            end
            S_MR: if (gap_zero) begin
                state_nxt = S_OCD_DEF;
                cmd_nxt   = CMD_LMR;
                ba_nxt    = BA_BITS'(BA_EMR1);
                addr_nxt  = emr1_base | OCD_MASK;
                gap_ld    = 1'b1;
            end
            S_OCD_DEF: if (gap_zero) begin
                state_nxt = S_OCD_EXIT;
                cmd_nxt   = CMD_LMR;
                ba_nxt    = BA_BITS'(BA_EMR1);
                addr_nxt  = emr1_base;
                gap_ld    = 1'b1;
            end
            S_OCD_EXIT: if (gap_zero) begin
                state_nxt = S_DLLW;
            end
            S_DLLW: if (dll_zero) begin
                state_nxt = S_DONE;
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
            end
            S_DONE: if (reinit_req) begin
                state_nxt  = S_PRE1;
                cmd_nxt    = CMD_PRE;
                addr_nxt   = AP_BIT;
                gap_ld     = 1'b1;
                gap_ld_val = LD_RP;
                capture    = 1'b1;
                done_nxt   = 1'b0;
                busy_nxt   = 1'b1;
            end
            default: state_nxt = S_PWR;
        endcase
    end

    // Registered outputs toward the PHY
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            cke_q  <= 1'b0;
            cmd_q  <= CMD_NOP;
            ba_q   <= '0;
            addr_q <= '0;
            busy_q <= 1'b1;
            done_q <= 1'b0;
        end else begin
            cke_q  <= cke_nxt;
            cmd_q  <= cmd_nxt;
            ba_q   <= ba_nxt;
            addr_q <= addr_nxt;
            busy_q <= busy_nxt;
            done_q <= done_nxt;
        end
    end

    // Auto-refresh repeat counter, cleared when PRE2 issues
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n)
            aref_cnt <= '0;
        else if (aref_clr)
            aref_cnt <= '0;
        else if (aref_inc)
            aref_cnt <= aref_cnt + 4'd1;
    end

    // Mode-register shadows, frozen for the rest of each sequence
    always_ff @(posedge ck) begin
        if (capture) begin
            mr_sh   <= mr_val;
            emr1_sh <= emr1_val;
            emr2_sh <= emr2_val;
            emr3_sh <= emr3_val;
        end
    end

    assign bus.init_cke  = cke_q;
    assign bus.init_cmd  = cmd_q;
    assign bus.init_ba   = ba_q;
    assign bus.init_addr = addr_q;
    assign bus.init_busy = busy_q;
    assign bus.init_done = done_q;

endmodule

// File: tb/tb_ddr2_init_seq.sv
// Scoreboard bench for ddr2_init_seq: two instances (N_AREF=2/T_DLLK=30 and N_AREF=1/T_DLLK=1).
module tb_ddr2_init_seq;
    import ddr2_pkg::*;

    localparam int AB = 14, BB = 3;
    localparam int TPU = 10, TNOP = 4, TRP = 3, TMRD = 2, TRFC = 5;
    localparam int EV_CKE = 0, EV_UNDONE = 1, EV_CMD = 2, EV_DONE = 3;

    typedef struct {
        int          t;
        int          kind;
        logic [3:0]  cmd;
        logic [BB-1:0] ba;
        logic [AB-1:0] addr;
    } ev_t;

    logic          ck = 1'b0;
    logic          rst_n = 1'b0;
    logic          reinit_req = 1'b0;
    logic [AB-1:0] mr_val, emr1_val, emr2_val, emr3_val;

    int errors = 0;
    int checks = 0;
    int cyc;
    int done_t [2];
    ev_t q0 [$];
    ev_t q1 [$];

    always #5 ck = ~ck;

    ddr2_init_seq_if #(.ADDR_BITS(AB), .BA_BITS(BB)) bus0 ();
    ddr2_init_seq_if #(.ADDR_BITS(AB), .BA_BITS(BB)) bus1 ();

    ddr2_init_seq #(.ADDR_BITS(AB), .BA_BITS(BB), .T_POWERUP(TPU), .T_NOP(TNOP), .T_RP(TRP),
                    .T_MRD(TMRD), .T_RFC(TRFC), .N_AREF(2), .T_DLLK(30), .CNT_W(17)) dut0 (
        .ck(ck), .rst_n(rst_n), .mr_val(mr_val), .emr1_val(emr1_val), .emr2_val(emr2_val),
        .emr3_val(emr3_val), .reinit_req(reinit_req), .bus(bus0));

    ddr2_init_seq #(.ADDR_BITS(AB), .BA_BITS(BB), .T_POWERUP(TPU), .T_NOP(TNOP), .T_RP(TRP),
                    .T_MRD(TMRD), .T_RFC(TRFC), .N_AREF(1), .T_DLLK(1), .CNT_W(17)) dut1 (
        .ck(ck), .rst_n(rst_n), .mr_val(mr_val), .emr1_val(emr1_val), .emr2_val(emr2_val),
        .emr3_val(emr3_val), .reinit_req(reinit_req), .bus(bus1));

    logic          cke_s  [2];
    logic [3:0]    cmd_s  [2];
    logic [BB-1:0] ba_s   [2];
    logic [AB-1:0] addr_s [2];
    logic          busy_s [2];
    logic          done_s [2];

    always_comb begin
        cke_s[0] = bus0.init_cke;  cmd_s[0] = bus0.init_cmd;  ba_s[0] = bus0.init_ba;
        addr_s[0] = bus0.init_addr; busy_s[0] = bus0.init_busy; done_s[0] = bus0.init_done;
        cke_s[1] = bus1.init_cke;  cmd_s[1] = bus1.init_cmd;  ba_s[1] = bus1.init_ba;
        addr_s[1] = bus1.init_addr; busy_s[1] = bus1.init_busy; done_s[1] = bus1.init_done;
    end

    always @(posedge ck or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic push(input int d, input int t, input int kind, input logic [3:0] cmd,
                        input int ba, input logic [AB-1:0] addr);
        ev_t e;
        e.t = t; e.kind = kind; e.cmd = cmd; e.ba = BB'(ba); e.addr = addr;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Expected event list for one sequence, using the mode values present at capture time
    task automatic expect_seq(input int d, input int start, input bit pwrup);
        int t, dll_t, nref, tdll;
        logic [AB-1:0] e1;
        nref = (d == 0) ? 2 : 1;
        tdll = (d == 0) ? 30 : 1;
        e1   = emr1_val & ~14'h0381;
        if (pwrup) begin
            push(d, TPU, EV_CKE, CMD_NOP, 0, '0);
            t = TPU + TNOP;
        end else begin
            push(d, start, EV_UNDONE, CMD_NOP, 0, '0);
            t = start;
        end
        push(d, t, EV_CMD, 4'b0010, 0, 14'h0400);                t += TRP;
        push(d, t, EV_CMD, 4'b0000, 2, emr2_val);                t += TMRD;
        push(d, t, EV_CMD, 4'b0000, 3, emr3_val);                t += TMRD;
        push(d, t, EV_CMD, 4'b0000, 1, e1);                      t += TMRD;
        push(d, t, EV_CMD, 4'b0000, 0, mr_val | 14'h0100);
        dll_t = t;                                               t += TMRD;
        push(d, t, EV_CMD, 4'b0010, 0, 14'h0400);                t += TRP;
        for (int k = 0; k < nref; k++) begin
            push(d, t, EV_CMD, 4'b0001, 0, '0);                  t += TRFC;
        end
        push(d, t, EV_CMD, 4'b0000, 0, mr_val & ~14'h0100);      t += TMRD;
        push(d, t, EV_CMD, 4'b0000, 1, e1 | 14'h0380);           t += TMRD;
        push(d, t, EV_CMD, 4'b0000, 1, e1);                      t += TMRD;
        done_t[d] = ((t > dll_t + tdll) ? t : dll_t + tdll) + 1;
        push(d, done_t[d], EV_DONE, CMD_NOP, 0, '0);
    endtask

    // ---------------- monitor ----------------
    task automatic check_ev(input int d, input int kind);
        ev_t e;
        int  n;
        checks++;
        n = (d == 0) ? q0.size() : q1.size();
        if (n == 0) begin
            errors++;
            $display("FAIL dut%0d_unexpected: got kind=%0d cmd=%b ba=%0d addr=0x%0h at cycle %0d, none expected",
                     d, kind, cmd_s[d], ba_s[d], addr_s[d], cyc);
            return;
        end
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        if (e.kind != kind || e.t != cyc ||
            (kind == EV_CMD && (e.cmd !== cmd_s[d] || e.ba !== ba_s[d] || e.addr !== addr_s[d]))) begin
            errors++;
            $display("FAIL dut%0d_event: got kind=%0d t=%0d cmd=%b ba=%0d addr=0x%0h, expected kind=%0d t=%0d cmd=%b ba=%0d addr=0x%0h",
                     d, kind, cyc, cmd_s[d], ba_s[d], addr_s[d], e.kind, e.t, e.cmd, e.ba, e.addr);
        end
    endtask

    logic cke_p [2];
    logic done_p [2];

    always @(negedge ck) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                cke_p[d]  <= 1'b0;
                done_p[d] <= 1'b0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (cke_s[d] && !cke_p[d]) check_ev(d, EV_CKE);
                if (!cke_s[d] && cke_p[d]) chk($sformatf("dut%0d_cke_drop", d), 32'(cke_s[d]), 32'd1);
                if (!done_s[d] && done_p[d]) begin
                    check_ev(d, EV_UNDONE);
                    chk($sformatf("dut%0d_busy_on_reinit", d), 32'(busy_s[d]), 32'd1);
                end
                if (cmd_s[d] != CMD_NOP) check_ev(d, EV_CMD);
                if (done_s[d] && !done_p[d]) begin
                    check_ev(d, EV_DONE);
                    chk($sformatf("dut%0d_busy_at_done", d), 32'(busy_s[d]), 32'd0);
                    chk($sformatf("dut%0d_cke_at_done", d), 32'(cke_s[d]), 32'd1);
                end
                cke_p[d]  <= cke_s[d];
                done_p[d] <= done_s[d];
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic check_reset(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_dut%0d_cke", tag, d),  32'(cke_s[d]),  32'd0);
            chk($sformatf("%s_dut%0d_cmd", tag, d),  32'(cmd_s[d]),  32'h7);
            chk($sformatf("%s_dut%0d_ba", tag, d),   32'(ba_s[d]),   32'd0);
            chk($sformatf("%s_dut%0d_addr", tag, d), 32'(addr_s[d]), 32'd0);
            chk($sformatf("%s_dut%0d_busy", tag, d), 32'(busy_s[d]), 32'd1);
            chk($sformatf("%s_dut%0d_done", tag, d), 32'(done_s[d]), 32'd0);
        end
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        expect_seq(0, 0, 1'b1);
        expect_seq(1, 0, 1'b1);
    endtask

    task automatic rand_vals();
        mr_val   = 14'($urandom);
        emr1_val = 14'($urandom);
        emr2_val = 14'($urandom);
        emr3_val = 14'($urandom);
    endtask

    // Called just after a falling edge; request is sampled on the next rising edge
    task automatic drive_cycle(input logic req);
        reinit_req = req;
        if (req)
            for (int d = 0; d < 2; d++)
                if (cyc >= done_t[d]) expect_seq(d, cyc + 1, 1'b0);
    endtask

    function automatic int last_done();
        return (done_t[0] > done_t[1]) ? done_t[0] : done_t[1];
    endfunction

    initial begin
        logic lvl;
        mr_val   = 14'h0632;
        emr1_val = 14'h0045;
        emr2_val = 14'($urandom);
        emr3_val = 14'($urandom);
        done_t[0] = 1 << 30;
        done_t[1] = 1 << 30;

        repeat (3) @(negedge ck);
        check_reset("rst");
        release_reset();

        // Abort in the middle of the auto-refresh phase
        while (cyc < 30) begin
            @(negedge ck);
            drive_cycle(1'b0);
        end
        #2 rst_n = 1'b0;
        q0.delete();
        q1.delete();
        #1 check_reset("abort");
        repeat (2) @(negedge ck);
        release_reset();

        // Full power-up again; a request pulse while busy must be ignored
        while (cyc < last_done() + 2) begin
            @(negedge ck);
            drive_cycle(cyc == 20);
        end

        // Directed re-init with a new EMR2 value
        @(negedge ck);
        rand_vals();
        emr2_val = 14'h0080;
        drive_cycle(1'b1);
        @(negedge ck);
        rand_vals();
        drive_cycle(1'b0);
        while (cyc < last_done() + 2) begin
            @(negedge ck);
            rand_vals();
            drive_cycle(1'b0);
        end

        // Random request levels and mode values changing every cycle
        lvl = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge ck);
            rand_vals();
            if ($urandom_range(0, 9) == 0) lvl = ~lvl;
            if (i >= 300 && i < 420) lvl = 1'b1;
            drive_cycle(lvl);
        end
        while (cyc < last_done() + 3) begin
            @(negedge ck);
            rand_vals();
            drive_cycle(1'b0);
        end

        chk("dut0_queue_drained", 32'(q0.size()), 32'd0);
        chk("dut1_queue_drained", 32'(q1.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
